// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Walks start / data / parity / stop, one bit
// period per baud tick, and drives the select and bit sources of the TX output
// mux. The mux output is the serial line, so idle and reset select the stop
// source (line high).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  tx_load,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [1:0]            select,
  output logic                  start_bit,
  output logic                  data_bit,
  output logic                  parity_bit,
  output logic                  stop_bit
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            select_reg, select_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  parity_reg, parity_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus next values of the registered outputs and datapath
  always_comb begin
    state_next  = state_reg;
    select_next = SEL_STOP;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    parity_next = parity_reg;
    cnt_next    = cnt_reg;
    shreg_next  = shreg_reg;

    // Busy drops one clock after the done pulse, so a load during the done
    // clock still sees busy and is ignored.
    if (done_reg) begin
      busy_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (tx_load && !busy_reg) begin
          state_next  = ARMED;
          shreg_next  = tx_data;
          parity_next = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          busy_next   = 1'b1;
        end
      end
      ARMED: begin
        // Wait for a fresh tick so the start bit is a full bit period.
        if (baud_tick) begin
          state_next = START;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
          cnt_next   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_next = {1'b1, shreg_reg[DATA_WIDTH-1:1]};
          if (cnt_reg == LAST_BIT) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Select follows the state being entered so it lines up with the state.
    case (state_next)
      START:   select_next = SEL_START;
      DATA:    select_next = SEL_DATA;
      PARITY:  select_next = SEL_PARITY;
      default: select_next = SEL_STOP;
    endcase
  end

  // Registered outputs and datapath; shift register refills with ones so the
  // data source idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_reg <= SEL_STOP;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      parity_reg <= 1'b0;
      cnt_reg    <= '0;
      shreg_reg  <= '1;
    end else begin
      select_reg <= select_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      parity_reg <= parity_next;
      cnt_reg    <= cnt_next;
      shreg_reg  <= shreg_next;
    end
  end

  assign select     = select_reg;
  assign tx_busy    = busy_reg;
  assign tx_done    = done_reg;
  assign data_bit   = shreg_reg[0];
  assign parity_bit = parity_reg;
  assign start_bit  = 1'b0;
  assign stop_bit   = 1'b1;

endmodule
